msrv_32_dmem_access_ctrl: RTL and testbench
===========================================

// Module: msrv_32_dmem_access_ctrl
// PURPOSE
//  Sequences every data-memory access of the msrv_32 core over the AHB-style dmem port.
//  Accepts one load/store at a time from the pipeline and checks alignment.
//  Drives address, write mask and replicated write data, then waits out bus wait states.
//  Captures read data and response, and hands the raw word plus load_size/unsigned/addr[1:0]
//  to msrv_32_load_unit. Stalls the pipeline while an access is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles before forced bus error (used only with MSRV32_DMEM_TIMEOUT_EN)
// PORTS
//  ms_riscv32_mp_clk_in         in   1   core clock
//  ms_riscv32_mp_rst_in         in   1   synchronous reset, active-high
//  req_valid_in                 in   1   pipeline access request
//  req_ready_out                out  1   controller can accept (1 only in IDLE)
//  req_is_store_in              in   1   1=store, 0=load
//  req_addr_in                  in   32  byte address (iadder output)
//  req_wdata_in                 in   32  store data (low bits significant)
//  req_size_in                  in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned_in              in   1   load zero-extend flag
//  ms_riscv32_mp_dmaddr_out     out  32  word-aligned bus address {addr[31:2],2'b00}
//  ms_riscv32_mp_dmreq_out      out  1   bus request strobe (one cycle)
//  ms_riscv32_mp_dmwr_req_out   out  1   write qualifier for dmreq
//  ms_riscv32_mp_dmwr_mask_out  out  4   byte lanes written
//  ms_riscv32_mp_dmdata_out     out  32  replicated store data
//  ms_risc32_mp_dmdata_in       in   32  bus read data
//  ahb_ready_in                 in   1   bus transfer complete
//  ahb_resp_in                  in   1   bus response, 1=error (valid with ahb_ready_in)
//  load_data_out                out  32  captured raw word to load unit
//  iadder_out_1_to_0_out        out  2   latched addr[1:0] to load unit
//  load_size_out                out  2   latched size to load unit
//  load_unsigned_out            out  1   latched unsigned flag to load unit
//  rsp_valid_out                out  1   one-cycle completion pulse
//  rsp_err_out                  out  1   bus error/timeout, qualified by rsp_valid_out
//  misaligned_out               out  1   alignment fault, qualified by rsp_valid_out
//  stall_out                    out  1   pipeline stall = (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and latches 0 except req_ready_out=1.
//  Reset mid-access: in-flight access dropped, no rsp_valid.
//  FSM states: IDLE, REQ, WAIT, RESP.
//  IDLE: on req_valid_in, latch all req_* fields.
//    Misaligned (half & addr[0], word & addr[1:0]!=0, size 11) -> RESP, misaligned_out=1, no bus access.
//    Otherwise -> REQ.
//  REQ: exactly one cycle. dmreq_out=1, dmwr_req_out=store, mask/data/address driven -> WAIT.
//  WAIT: address/mask/data held, dmreq_out=0.
//    On ahb_ready_in=1: load_data_out<=dmdata_in (loads only; stores leave it unchanged);
//    rsp_err<=ahb_resp_in -> RESP.
//  RESP: rsp_valid_out=1 for one cycle -> IDLE. A new request can be accepted in the following cycle.
//  Latency: accept cycle N, REQ N+1, WAIT N+2, earliest rsp_valid N+3.
//    Each extra low cycle of ahb_ready_in adds 1. Misaligned: rsp_valid at N+1.
//  Write mask:
//    byte -> 4'b0001<<addr[1:0];
//    half -> 4'b0011<<{addr[1],1'b0};
//    word -> 4'b1111;
//    loads -> 4'b0000.
//  Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load-unit outputs (iadder/size/unsigned) stay latched until the next accept.
//  rsp_err_out and misaligned_out are never both 1.
//  req_valid_in is ignored outside IDLE (no queuing).
// CONFIGURATION
//  MSRV32_DMEM_TIMEOUT_EN defined:
//    wait counter cleared on entry to WAIT, incremented each WAIT cycle with ahb_ready_in=0.
//    When it reaches TIMEOUT_CYCLES -> RESP with rsp_err_out=1; load_data_out unchanged.
//  Not defined: WAIT lasts indefinitely; no counter logic; TIMEOUT_CYCLES unused.
// TESTING
//  1 Reset 2 cycles -> stall_out=0, req_ready_out=1, dmreq/dmwr_req/rsp_valid/masks all 0.
//  2 LBU addr 0x00001001, ahb_ready_in high, dmdata 0xA5A5A5A5
//    -> dmaddr 0x00001000, mask 0000, rsp_valid at N+3, load_data_out 0xA5A5A5A5,
//       iadder 01, size 00, unsigned 1.
//  3 SH addr 0x00002002 wdata 0x0000BEEF -> dmwr_req 1, mask 1100, dmdata_out 0xBEEFBEEF, rsp_err 0.
//  4 LW addr 0x00003003 -> rsp_valid and misaligned_out at N+1; dmreq_out never asserted.
//  5 SB addr 0x10 with 3 wait states, then ahb_ready_in=1, ahb_resp_in=1
//    -> rsp_err_out=1 at N+6, stall_out high N+1..N+6.
//    Repeat and assert reset in WAIT -> IDLE next edge, no rsp_valid.
//  6 (MSRV32_DMEM_TIMEOUT_EN) ahb_ready_in held 0
//    -> rsp_valid with rsp_err_out=1 after 16 WAIT cycles.
//    Without the macro, no rsp_valid for 100 cycles.

Source files
------------

// File: rtl/msrv_32_dmem_access_ctrl.sv
// Data-memory access sequencer for the msrv_32 core: alignment check, AHB-style request, wait-state handling.
// Optional bus-timeout watchdog enabled by defining MSRV32_DMEM_TIMEOUT_EN.
module msrv_32_dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_is_store_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmreq_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  input  logic [31:0] ms_risc32_mp_dmdata_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] load_data_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic        rsp_valid_out,
  output logic        rsp_err_out,
  output logic        misaligned_out,
  output logic        stall_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  state_e      state_q, state_d;
  logic [31:0] dmaddr_q, dmaddr_d;
  logic        dmreq_q, dmreq_d;
  logic        dmwr_q, dmwr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] dmdata_q, dmdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  iadder_q, iadder_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        misaligned_q, misaligned_d;
  logic        stall_q, stall_d;
  logic        ready_q, ready_d;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic        misaligned_c;
  logic [3:0]  lane_mask_c;
  logic [31:0] lane_data_c;

  // Alignment check and byte-lane steering of the incoming request
  always_comb begin
    misaligned_c = 1'b0;
    lane_mask_c  = 4'b0000;
    lane_data_c  = 32'h0;
    unique case (req_size_in)
      2'b00: begin
        lane_mask_c = 4'b0001 << req_addr_in[1:0];
        lane_data_c = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        misaligned_c = req_addr_in[0];
        lane_mask_c  = 4'b0011 << {req_addr_in[1], 1'b0};
        lane_data_c  = {2{req_wdata_in[15:0]}};
      end
      2'b10: begin
        misaligned_c = (req_addr_in[1:0] != 2'b00);
        lane_mask_c  = 4'b1111;
        lane_data_c  = req_wdata_in;
      end
      default: misaligned_c = 1'b1;
    endcase
    if (!req_is_store_in) begin
      lane_mask_c = 4'b0000;
      lane_data_c = 32'h0;
    end
  end

  always_comb begin
    state_d      = state_q;
    dmaddr_d     = dmaddr_q;
    dmwr_d       = dmwr_q;
    mask_d       = mask_q;
    dmdata_d     = dmdata_q;
    load_data_d  = load_data_q;
    iadder_d     = iadder_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    rsp_err_d    = rsp_err_q;
    misaligned_d = misaligned_q;
`ifdef MSRV32_DMEM_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          iadder_d     = req_addr_in[1:0];
          size_d       = req_size_in;
          unsigned_d   = req_unsigned_in;
          misaligned_d = misaligned_c;
          rsp_err_d    = 1'b0;
          if (misaligned_c) begin
            state_d = S_RESP;
          end else begin
            state_d  = S_REQ;
            dmaddr_d = {req_addr_in[31:2], 2'b00};
            dmwr_d   = req_is_store_in;
            mask_d   = lane_mask_c;
            dmdata_d = lane_data_c;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef MSRV32_DMEM_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (ahb_ready_in) begin
          if (!dmwr_q) load_data_d = ms_risc32_mp_dmdata_in;
          rsp_err_d = ahb_resp_in;
          state_d   = S_RESP;
        end
`ifdef MSRV32_DMEM_TIMEOUT_EN
        // Watchdog: the stalled transfer is abandoned and reported as a bus error
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it
    dmreq_d     = (state_d == S_REQ);
    rsp_valid_d = (state_d == S_RESP);
    stall_d     = (state_d != S_IDLE);
    ready_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= S_IDLE;
      dmaddr_q     <= 32'h0;
      dmreq_q      <= 1'b0;
      dmwr_q       <= 1'b0;
      mask_q       <= 4'b0000;
      dmdata_q     <= 32'h0;
      load_data_q  <= 32'h0;
      iadder_q     <= 2'b00;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
      stall_q      <= 1'b0;
      ready_q      <= 1'b1;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dmaddr_q     <= dmaddr_d;
      dmreq_q      <= dmreq_d;
      dmwr_q       <= dmwr_d;
      mask_q       <= mask_d;
      dmdata_q     <= dmdata_d;
      load_data_q  <= load_data_d;
      iadder_q     <= iadder_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      misaligned_q <= misaligned_d;
      stall_q      <= stall_d;
      ready_q      <= ready_d;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign req_ready_out               = ready_q;
  assign ms_riscv32_mp_dmaddr_out    = dmaddr_q;
  assign ms_riscv32_mp_dmreq_out     = dmreq_q;
  assign ms_riscv32_mp_dmwr_req_out  = dmwr_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmdata_out    = dmdata_q;
  assign load_data_out               = load_data_q;
  assign iadder_out_1_to_0_out       = iadder_q;
  assign load_size_out               = size_q;
  assign load_unsigned_out           = unsigned_q;
  assign rsp_valid_out               = rsp_valid_q;
  assign rsp_err_out                 = rsp_err_q;
  assign misaligned_out              = misaligned_q;
  assign stall_out                   = stall_q;

endmodule

// File: tb/tb_msrv_32_dmem_access_ctrl.sv
// Directed table-driven bench for msrv_32_dmem_access_ctrl, plus reset-in-WAIT and stuck-bus sequences.
module tb_msrv_32_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_is_store_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic [31:0] dmaddr;
  logic        dmreq;
  logic        dmwr;
  logic [3:0]  dmmask;
  logic [31:0] dmdata_out;
  logic [31:0] dmdata_in;
  logic        ahb_ready_in;
  logic        ahb_resp_in;
  logic [31:0] load_data_out;
  logic [1:0]  iadder_out;
  logic [1:0]  load_size_out;
  logic        load_unsigned_out;
  logic        rsp_valid_out;
  logic        rsp_err_out;
  logic        misaligned_out;
  logic        stall_out;

  msrv_32_dmem_access_ctrl dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .req_valid_in                (req_valid_in),
    .req_ready_out               (req_ready_out),
    .req_is_store_in             (req_is_store_in),
    .req_addr_in                 (req_addr_in),
    .req_wdata_in                (req_wdata_in),
    .req_size_in                 (req_size_in),
    .req_unsigned_in             (req_unsigned_in),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmreq_out     (dmreq),
    .ms_riscv32_mp_dmwr_req_out  (dmwr),
    .ms_riscv32_mp_dmwr_mask_out (dmmask),
    .ms_riscv32_mp_dmdata_out    (dmdata_out),
    .ms_risc32_mp_dmdata_in      (dmdata_in),
    .ahb_ready_in                (ahb_ready_in),
    .ahb_resp_in                 (ahb_resp_in),
    .load_data_out               (load_data_out),
    .iadder_out_1_to_0_out       (iadder_out),
    .load_size_out               (load_size_out),
    .load_unsigned_out           (load_unsigned_out),
    .rsp_valid_out               (rsp_valid_out),
    .rsp_err_out                 (rsp_err_out),
    .misaligned_out              (misaligned_out),
    .stall_out                   (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int unsigned waits;
    logic        resp;
    logic        noise;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_ld;
  vec_t        vecs[12];

  function automatic vec_t mk(string name, logic st, logic [31:0] addr, logic [31:0] wdata,
                              logic [1:0] size, logic uns, logic [31:0] rdata, int unsigned waits,
                              logic resp, logic noise, logic exp_mis, logic [31:0] exp_addr,
                              logic [3:0] exp_mask, logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.st = st; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rdata = rdata; v.waits = waits; v.resp = resp; v.noise = noise; v.exp_mis = exp_mis;
    v.exp_addr = exp_addr; v.exp_mask = exp_mask; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_load_fields(input vec_t v);
    chk({v.name, " iadder"}, 32'(iadder_out), 32'(v.addr[1:0]));
    chk({v.name, " size"}, 32'(load_size_out), 32'(v.size));
    chk({v.name, " unsigned"}, 32'(load_unsigned_out), 32'(v.uns));
    chk({v.name, " load_data"}, load_data_out, exp_ld);
  endtask

  task automatic run_vec(input vec_t v);
    req_is_store_in = v.st;
    req_addr_in     = v.addr;
    req_wdata_in    = v.wdata;
    req_size_in     = v.size;
    req_unsigned_in = v.uns;
    req_valid_in    = 1'b1;
    ahb_ready_in    = 1'b0;
    ahb_resp_in     = v.resp;
    dmdata_in       = v.rdata;
    chk({v.name, " ready before accept"}, 32'(req_ready_out), 32'd1);
    tick();
    req_valid_in = 1'b0;
    if (v.exp_mis) begin
      chk({v.name, " mis rsp_valid"}, 32'(rsp_valid_out), 32'd1);
      chk({v.name, " misaligned"}, 32'(misaligned_out), 32'd1);
      chk({v.name, " mis rsp_err"}, 32'(rsp_err_out), 32'd0);
      chk({v.name, " mis dmreq"}, 32'(dmreq), 32'd0);
      chk_load_fields(v);
    end else begin
      chk({v.name, " dmreq"}, 32'(dmreq), 32'd1);
      chk({v.name, " dmwr"}, 32'(dmwr), 32'(v.st));
      chk({v.name, " dmaddr"}, dmaddr, v.exp_addr);
      chk({v.name, " mask"}, 32'(dmmask), 32'(v.exp_mask));
      if (v.st) chk({v.name, " dmdata"}, dmdata_out, v.exp_wdata);
      chk({v.name, " stall req"}, 32'(stall_out), 32'd1);
      chk({v.name, " ready req"}, 32'(req_ready_out), 32'd0);
      tick();
      for (int i = 0; i <= int'(v.waits); i++) begin
        ahb_ready_in = (i == int'(v.waits));
        if (v.noise) begin
          req_valid_in    = 1'b1;
          req_addr_in     = 32'hFFFF_FFF3;
          req_size_in     = 2'b00;
          req_unsigned_in = ~v.uns;
          req_is_store_in = ~v.st;
        end
        chk({v.name, " wait dmreq"}, 32'(dmreq), 32'd0);
        chk({v.name, " wait rsp_valid"}, 32'(rsp_valid_out), 32'd0);
        chk({v.name, " wait stall"}, 32'(stall_out), 32'd1);
        chk({v.name, " wait dmaddr"}, dmaddr, v.exp_addr);
        tick();
      end
      ahb_ready_in = 1'b0;
      req_valid_in = 1'b0;
      if (!v.st) exp_ld = v.rdata;
      chk({v.name, " rsp_valid"}, 32'(rsp_valid_out), 32'd1);
      chk({v.name, " rsp_err"}, 32'(rsp_err_out), 32'(v.resp));
      chk({v.name, " misaligned"}, 32'(misaligned_out), 32'd0);
      chk({v.name, " rsp stall"}, 32'(stall_out), 32'd1);
      chk_load_fields(v);
    end
    tick();
    chk({v.name, " idle rsp_valid"}, 32'(rsp_valid_out), 32'd0);
    chk({v.name, " idle stall"}, 32'(stall_out), 32'd0);
    chk({v.name, " idle ready"}, 32'(req_ready_out), 32'd1);
    chk({v.name, " idle dmreq"}, 32'(dmreq), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ld = 32'h0;
    rst = 1'b1;
    req_valid_in = 1'b0; req_is_store_in = 1'b0; req_addr_in = 32'h0; req_wdata_in = 32'h0;
    req_size_in = 2'b00; req_unsigned_in = 1'b0; dmdata_in = 32'h0;
    ahb_ready_in = 1'b0; ahb_resp_in = 1'b0;

    //          name      st    addr          wdata         sz     uns   rdata         w  resp  nz    mis   exp_addr      mask     exp_wdata
    vecs[0]  = mk("LBU",  1'b0, 32'h00001001, 32'h00000000, 2'b00, 1'b1, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 1'b0, 32'h00001000, 4'b0000, 32'h0);
    vecs[1]  = mk("SH",   1'b1, 32'h00002002, 32'h0000BEEF, 2'b01, 1'b0, 32'h5555AAAA, 0, 1'b0, 1'b0, 1'b0, 32'h00002000, 4'b1100, 32'hBEEFBEEF);
    vecs[2]  = mk("LWmis",1'b0, 32'h00003003, 32'h00000000, 2'b10, 1'b0, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
    vecs[3]  = mk("SBerr",1'b1, 32'h00000010, 32'h12345677, 2'b00, 1'b0, 32'h5555AAAA, 3, 1'b1, 1'b0, 1'b0, 32'h00000010, 4'b0001, 32'h77777777);
    vecs[4]  = mk("LWnz", 1'b0, 32'h00004000, 32'h00000000, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b0, 1'b1, 1'b0, 32'h00004000, 4'b0000, 32'h0);
    vecs[5]  = mk("SW",   1'b1, 32'h00005004, 32'hCAFEF00D, 2'b10, 1'b0, 32'h13579BDF, 2, 1'b0, 1'b0, 1'b0, 32'h00005004, 4'b1111, 32'hCAFEF00D);
    vecs[6]  = mk("SB3",  1'b1, 32'h00006003, 32'h000000AB, 2'b00, 1'b0, 32'h2468ACE0, 0, 1'b0, 1'b0, 1'b0, 32'h00006000, 4'b1000, 32'hABABABAB);
    vecs[7]  = mk("LHmis",1'b0, 32'h00007001, 32'h00000000, 2'b01, 1'b0, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
    vecs[8]  = mk("SZ11", 1'b1, 32'h00008000, 32'h11111111, 2'b11, 1'b0, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0);
    vecs[9]  = mk("SH0",  1'b1, 32'h00009000, 32'h00001234, 2'b01, 1'b0, 32'h0F0F0F0F, 0, 1'b0, 1'b0, 1'b0, 32'h00009000, 4'b0011, 32'h12341234);
    vecs[10] = mk("LHU",  1'b0, 32'h0000A002, 32'h00000000, 2'b01, 1'b1, 32'h11223344, 2, 1'b0, 1'b0, 1'b0, 32'h0000A000, 4'b0000, 32'h0);
    vecs[11] = mk("SB1",  1'b1, 32'h0000B001, 32'h000000C3, 2'b00, 1'b0, 32'h99999999, 1, 1'b0, 1'b0, 1'b0, 32'h0000B000, 4'b0010, 32'hC3C3C3C3);

    tick();
    tick();
    chk("reset stall", 32'(stall_out), 32'd0);
    chk("reset ready", 32'(req_ready_out), 32'd1);
    chk("reset dmreq", 32'(dmreq), 32'd0);
    chk("reset dmwr", 32'(dmwr), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("reset mask", 32'(dmmask), 32'd0);
    chk("reset load_data", load_data_out, 32'h0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 12; k++) run_vec(vecs[k]);

    // Reset while the bus is stalled in WAIT drops the access
    req_is_store_in = 1'b1; req_addr_in = 32'h00000010; req_wdata_in = 32'h000000EE;
    req_size_in = 2'b00; req_unsigned_in = 1'b0; req_valid_in = 1'b1; ahb_ready_in = 1'b0;
    tick();
    req_valid_in = 1'b0;
    tick();
    tick();
    chk("rstwait stall before", 32'(stall_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ld = 32'h0;
    chk("rstwait stall", 32'(stall_out), 32'd0);
    chk("rstwait ready", 32'(req_ready_out), 32'd1);
    chk("rstwait rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rstwait mask", 32'(dmmask), 32'd0);
    chk("rstwait load_data", load_data_out, exp_ld);
    ahb_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstwait no rsp", 32'(rsp_valid_out), 32'd0);
    end
    ahb_ready_in = 1'b0;

    // Bus that never signals ready
    req_is_store_in = 1'b0; req_addr_in = 32'h0000C000; req_size_in = 2'b10;
    req_unsigned_in = 1'b0; dmdata_in = 32'h7777_7777; req_valid_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    tick();
`ifdef MSRV32_DMEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("timeout early rsp", 32'(rsp_valid_out), 32'd0);
      tick();
    end
    chk("timeout rsp_valid", 32'(rsp_valid_out), 32'd1);
    chk("timeout rsp_err", 32'(rsp_err_out), 32'd1);
    chk("timeout misaligned", 32'(misaligned_out), 32'd0);
    chk("timeout load_data", load_data_out, exp_ld);
    tick();
    chk("timeout idle", 32'(stall_out), 32'd0);
`else
    begin
      int unsigned seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (rsp_valid_out !== 1'b0) seen++;
        tick();
      end
      chk("stuck bus rsp_valid count", 32'(seen), 32'd0);
      chk("stuck bus stall", 32'(stall_out), 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stuck bus recover", 32'(req_ready_out), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
